// File: rtl/adder_response_checker.sv
// rtl/adder_response_checker.sv - checks observed adder vectors against (a + b) mod 2^WIDTH over a counted session
// Optional macro ADDER_CHECKER_CAPTURE_EN adds capture of the first mismatching vector.
module adder_response_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef ADDER_CHECKER_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_sum,
  output logic [CNT_W-1:0] fail_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] vec_inc;
  logic             ready;
  logic             accept;
  logic             mismatch;

`ifdef ADDER_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic [WIDTH-1:0] fail_sum_q, fail_sum_d;
  logic [CNT_W-1:0] fail_idx_q, fail_idx_d;
`endif

  // Carry-out is discarded by the WIDTH-bit result.
  assign expected = a + b;
  assign mismatch = (sum != expected);
  assign vec_inc  = vec_cnt_q + 1'b1;
  assign ready    = (state_q == RUN) && (vec_cnt_q < num_vec_q);
  assign accept   = ready && in_valid;

  always_comb begin
    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    num_vec_d = num_vec_q;
`ifdef ADDER_CHECKER_CAPTURE_EN
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_sum_d = fail_sum_q;
    fail_idx_d = fail_idx_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_cnt_d = '0;
          err_cnt_d = '0;
          num_vec_d = num_vec;
          state_d   = (num_vec == '0) ? DONE : RUN;
`ifdef ADDER_CHECKER_CAPTURE_EN
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_sum_d = '0;
          fail_idx_d = '0;
`endif
        end
      end
      RUN: begin
        if (accept) begin
          vec_cnt_d = vec_inc;
          if (mismatch && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
`ifdef ADDER_CHECKER_CAPTURE_EN
          // err_cnt is still zero only until the session's first mismatch.
          if (mismatch && (err_cnt_q == '0)) begin
            fail_a_d   = a;
            fail_b_d   = b;
            fail_sum_d = sum;
            fail_idx_d = vec_cnt_q;
          end
`endif
          if (vec_inc == num_vec_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      num_vec_q <= '0;
`ifdef ADDER_CHECKER_CAPTURE_EN
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_sum_q <= '0;
      fail_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      num_vec_q <= num_vec_d;
`ifdef ADDER_CHECKER_CAPTURE_EN
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_sum_q <= fail_sum_d;
      fail_idx_q <= fail_idx_d;
`endif
    end
  end

  assign in_ready = ready;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign pass     = (state_q == DONE) && (err_cnt_q == '0);
  assign vec_cnt  = vec_cnt_q;
  assign err_cnt  = err_cnt_q;

`ifdef ADDER_CHECKER_CAPTURE_EN
  assign fail_a   = fail_a_q;
  assign fail_b   = fail_b_q;
  assign fail_sum = fail_sum_q;
  assign fail_idx = fail_idx_q;
`endif

endmodule
